uart_tx_parity: RTL and testbench

//  UART transmitter, the transmit half of the UART block. Serialises one word per frame:

---
 rtl/uart_tx_parity.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_tx_parity.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_parity.sv
// -----------------------------------------------------------------------------
// uart_tx_parity
// Transmit half of the UART block. Sends one frame per accepted word:
// start bit (0), Data_bits-1 payload bits LSB first, one even-parity bit,
// stop bit (1). Bit timing is counted on the shared oversampling strobe
// s_ticks: Dt_ticks strobes per start/data/parity bit, Sp_ticks for stop.
//
// Optional feature macro: UART_TX_HOLD_REG_EN
//   defined   -> one-entry holding register; a word accepted while a frame
//                is in flight is sent back-to-back after the current stop bit,
//                and tx_busy reflects only the holding register.
//   undefined -> no holding register; tx_busy is high while a frame is active.
//
// Ports
//   clk           in   system clock, all logic on posedge
//   Reset         in   synchronous active-high reset (aborts any frame)
//   s_ticks       in   oversampling strobe, one clk wide
//   tx_start      in   request to send data_in
//   data_in       in   payload (Data_bits-1 bits), sampled on accept only
//   tx            out  serial line, idle high, registered
//   tx_busy       out  1 = tx_start is ignored this cycle, registered
//   tx_done_tick  out  one-clk pulse after the last stop-bit strobe, registered
// -----------------------------------------------------------------------------
module uart_tx_parity #(
  parameter int Data_bits = 9,
  parameter int Dt_ticks  = 16,
  parameter int Sp_ticks  = 16
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 s_ticks,
  input  logic                 tx_start,
  input  logic [Data_bits-2:0] data_in,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int W     = Data_bits - 1;
  localparam int S_MAX = (Dt_ticks > Sp_ticks) ? Dt_ticks : Sp_ticks;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = $clog2(Data_bits);

  localparam logic [S_W-1:0] S_ZERO  = {S_W{1'b0}};
  localparam logic [S_W-1:0] S_ONE   = {{(S_W-1){1'b0}}, 1'b1};
  localparam logic [S_W-1:0] DT_LAST = S_W'(Dt_ticks - 1);
  localparam logic [S_W-1:0] SP_LAST = S_W'(Sp_ticks - 1);
  localparam logic [N_W-1:0] N_ZERO  = {N_W{1'b0}};
  localparam logic [N_W-1:0] N_ONE   = {{(N_W-1){1'b0}}, 1'b1};
  localparam logic [N_W-1:0] N_LAST  = N_W'(Data_bits - 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity bit: makes the total count of ones over payload+parity even.
  function automatic logic even_parity(input logic [W-1:0] word);
    return ^word;
  endfunction

  state_t         state_r, state_s;
  logic [S_W-1:0] s_r, s_s;
  logic [N_W-1:0] n_r, n_s;
  logic [W-1:0]   shift_r, shift_s;
  logic           parity_r, parity_s;
  logic           tx_r, tx_s;
  logic           busy_r, busy_s;
  logic           done_r, done_s;
  logic           accept_s;
  logic           load_s;
  logic [W-1:0]   load_word_s;
`ifdef UART_TX_HOLD_REG_EN
  logic           hold_valid_r, hold_valid_s;
  logic [W-1:0]   hold_word_r, hold_word_s;
`endif

  // Next-state, counter, datapath and output decode for the frame FSM.
  always_comb begin
    state_s     = state_r;
    s_s         = s_r;
    n_s         = n_r;
    shift_s     = shift_r;
    parity_s    = parity_r;
    done_s      = 1'b0;
    load_s      = 1'b0;
    load_word_s = data_in;
    accept_s    = tx_start & ~busy_r;
    busy_s      = 1'b0;
    tx_s        = 1'b1;
`ifdef UART_TX_HOLD_REG_EN
    hold_valid_s = hold_valid_r;
    hold_word_s  = hold_word_r;
`endif

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      START: begin
        if (s_ticks) begin
          if (s_r == DT_LAST) begin
            s_s     = S_ZERO;
            state_s = DATA;
          end else begin
            s_s = s_r + S_ONE;
          end
        end else begin
          s_s = s_r;
        end
      end
      DATA: begin
        if (s_ticks) begin
          if (s_r == DT_LAST) begin
            s_s     = S_ZERO;
            shift_s = shift_r >> 1;
            n_s     = n_r + N_ONE;
            if (n_r == N_LAST) begin
              state_s = PARITY;
            end else begin
              state_s = DATA;
            end
          end else begin
            s_s = s_r + S_ONE;
          end
        end else begin
          s_s = s_r;
        end
      end
      PARITY: begin
        if (s_ticks) begin
          if (s_r == DT_LAST) begin
            s_s     = S_ZERO;
            state_s = STOP;
          end else begin
            s_s = s_r + S_ONE;
          end
        end else begin
          s_s = s_r;
        end
      end
      STOP: begin
        if (s_ticks) begin
          if (s_r == SP_LAST) begin
            s_s    = S_ZERO;
            done_s = 1'b1;
`ifdef UART_TX_HOLD_REG_EN
            // Chain straight into the next frame: no idle-high gap.
            if (hold_valid_r) begin
              load_s       = 1'b1;
              load_word_s  = hold_word_r;
              hold_valid_s = 1'b0;
            end else if (accept_s) begin
              load_s = 1'b1;
            end else begin
              state_s = IDLE;
            end
`else
            state_s = IDLE;
`endif
          end else begin
            s_s = s_r + S_ONE;
          end
        end else begin
          s_s = s_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

`ifdef UART_TX_HOLD_REG_EN
    // An accepted word that did not go straight to the shifter is parked.
    if (accept_s && !load_s) begin
      hold_valid_s = 1'b1;
      hold_word_s  = data_in;
    end else begin
      hold_valid_s = hold_valid_s;
    end
`endif

    if (load_s) begin
      state_s  = START;
      shift_s  = load_word_s;
      parity_s = even_parity(load_word_s);
      s_s      = S_ZERO;
      n_s      = N_ZERO;
    end else begin
      shift_s = shift_s;
    end

`ifdef UART_TX_HOLD_REG_EN
    busy_s = hold_valid_s;
`else
    busy_s = (state_s != IDLE);
`endif

    // Line level is decoded from the next state so tx is a clean flop output.
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      PARITY:  tx_s = parity_s;
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // State, counters, shifter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r  <= IDLE;
      s_r      <= S_ZERO;
      n_r      <= N_ZERO;
      shift_r  <= {W{1'b0}};
      parity_r <= 1'b0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef UART_TX_HOLD_REG_EN
      hold_valid_r <= 1'b0;
      hold_word_r  <= {W{1'b0}};
`endif
    end else begin
      state_r  <= state_s;
      s_r      <= s_s;
      n_r      <= n_s;
      shift_r  <= shift_s;
      parity_r <= parity_s;
      tx_r     <= tx_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
`ifdef UART_TX_HOLD_REG_EN
      hold_valid_r <= hold_valid_s;
      hold_word_r  <= hold_word_s;
`endif
    end
  end

  assign tx           = tx_r;
  assign tx_busy      = busy_r;
  assign tx_done_tick = done_r;

endmodule

// File: tb/tb_uart_tx_parity.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_parity
// Randomised bench for uart_tx_parity. A frame-level model (tick budget per
// frame, optional one-word hold slot) predicts acceptance, tx_busy and the
// line level; accepted words go into a scoreboard queue. A separate monitor
// captures each frame on the line one sample per s_ticks, decodes it like a
// receiver and compares against the popped expected word.
// -----------------------------------------------------------------------------
module tb_uart_tx_parity;

  localparam int DB    = 9;
  localparam int DT    = 16;
  localparam int SP    = 16;
  localparam int W     = DB - 1;
  localparam int NBITS = W + 3;                 // start, payload, parity, stop
  localparam int FRAME = (W + 2) * DT + SP;     // strobes per frame

  logic         clk = 1'b0;
  logic         Reset;
  logic         s_ticks;
  logic         tx_start;
  logic [W-1:0] data_in;
  logic         tx;
  logic         tx_busy;
  logic         tx_done_tick;

  uart_tx_parity #(.Data_bits(DB), .Dt_ticks(DT), .Sp_ticks(SP)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .s_ticks      (s_ticks),
    .tx_start     (tx_start),
    .data_in      (data_in),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q[$];

  // frame-level model state
  logic         m_valid = 1'b0;
  logic         m_active = 1'b0;
  logic         m_hold = 1'b0;
  int           m_left = 0;
  logic [W-1:0] m_cur = '0;
  logic [W-1:0] m_hold_word = '0;

  // monitor state
  logic             in_frame = 1'b0;
  logic             expect_done = 1'b0;
  int               tick_idx = 0;
  logic [FRAME-1:0] samples = '0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_frame(input string name, input logic [FRAME-1:0] act, input logic [FRAME-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line level for every strobe of a frame carrying word w.
  function automatic logic [FRAME-1:0] frame_bits(input logic [W-1:0] w);
    logic [NBITS-1:0] bits;
    logic [FRAME-1:0] f;
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[i+1] = w[i];
    bits[W+1] = (($countones(w) % 2) == 1);
    bits[W+2] = 1'b1;
    for (int c = 0; c < FRAME; c++) f[c] = (c < (W + 2) * DT) ? bits[c / DT] : bits[W+2];
    return f;
  endfunction

  function automatic logic m_busy_f();
`ifdef UART_TX_HOLD_REG_EN
    return m_hold;
`else
    return m_active;
`endif
  endfunction

  function automatic logic m_tx_f();
    logic [FRAME-1:0] f;
    if (!m_active) return 1'b1;
    f = frame_bits(m_cur);
    return f[FRAME - m_left];
  endfunction

  function automatic logic tick_rand();
    return ($urandom_range(0, 3) != 0);
  endfunction

  // One clock: check outputs against the model, drive inputs, advance model.
  task automatic step(input logic tick, input logic start, input logic [W-1:0] word, input logic rst);
    logic completing;
    logic accept;
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk_bit("tx_busy", tx_busy, m_busy_f());
      chk_bit("tx_line", tx, m_tx_f());
    end
    Reset    = rst;
    s_ticks  = tick;
    tx_start = start;
    data_in  = word;
    if (rst) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_hold   = 1'b0;
      m_left   = 0;
      sb_q.delete();
    end else begin
      completing = m_active && tick && (m_left == 1);
      accept     = start && !m_busy_f();
      if (accept) sb_q.push_back(word);
      if (m_active && tick) m_left--;
      if (completing) begin
        if (m_hold) begin
          m_cur  = m_hold_word;
          m_left = FRAME;
          m_hold = 1'b0;
        end else if (accept) begin
          m_cur  = word;
          m_left = FRAME;
        end else begin
          m_active = 1'b0;
        end
      end else if (accept) begin
        if (!m_active) begin
          m_active = 1'b1;
          m_cur    = word;
          m_left   = FRAME;
        end else begin
          m_hold      = 1'b1;
          m_hold_word = word;
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((m_active || m_hold) && n < 4000) begin
      step(tick_rand(), 1'b0, '0, 1'b0);
      n++;
    end
    if (m_active || m_hold) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual still busy required idle within 4000 cycles");
    end
    repeat (3) step(tick_rand(), 1'b0, '0, 1'b0);
    chk_bit("scoreboard_empty", sb_q.size() == 0, 1'b1);
  endtask

  task automatic compare_frame(input logic [FRAME-1:0] smp);
    logic [W-1:0] exp_w;
    logic [W-1:0] rx_w;
    logic         par_ok;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: actual frame %h required none", smp);
    end else begin
      exp_w = sb_q.pop_front();
      chk_frame("frame_waveform", smp, frame_bits(exp_w));
      for (int i = 0; i < W; i++) rx_w[i] = smp[(i + 1) * DT + DT / 2];
      par_ok = (smp[DT / 2] == 1'b0) && (smp[(W + 2) * DT + SP / 2] == 1'b1) &&
               ((^rx_w) == smp[(W + 1) * DT + DT / 2]);
      chk_word("rx_data", rx_w, exp_w);
      chk_bit("rx_parity_ok", par_ok, 1'b1);
    end
  endtask

  // Monitor: loopback receiver sampling the line once per strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (Reset === 1'b1) begin
        in_frame    = 1'b0;
        expect_done = 1'b0;
        tick_idx    = 0;
      end else begin
        if (expect_done) begin
          chk_bit("done_pulse", tx_done_tick, 1'b1);
          expect_done = 1'b0;
        end else if (tx_done_tick !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: actual %b required 0 at %0t", tx_done_tick, $time);
        end
        if (!in_frame && tx === 1'b0) begin
          in_frame = 1'b1;
          tick_idx = 0;
        end
        if (in_frame && s_ticks) begin
          samples[tick_idx] = tx;
          tick_idx++;
          if (tick_idx == FRAME) begin
            in_frame    = 1'b0;
            expect_done = 1'b1;
            compare_frame(samples);
          end
        end
      end
    end
  end

  initial begin
    Reset    = 1'b1;
    s_ticks  = 1'b0;
    tx_start = 1'b0;
    data_in  = '0;
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);

    // quiet line after reset
    repeat (1000) step(tick_rand(), 1'b0, '0, 1'b0);

    // single frames, even and odd payload weight
    step(tick_rand(), 1'b1, 8'hA5, 1'b0);
    drain();
    step(tick_rand(), 1'b1, 8'h07, 1'b0);
    drain();

    // request in the middle of a frame
    step(tick_rand(), 1'b1, 8'hA5, 1'b0);
    repeat (60) step(tick_rand(), 1'b0, '0, 1'b0);
    step(tick_rand(), 1'b1, 8'h3C, 1'b0);
    drain();

    // reset while shifting data, then a clean frame
    step(1'b1, 1'b1, 8'hC3, 1'b0);
    repeat (40) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    repeat (5) step(1'b1, 1'b0, '0, 1'b0);
    step(tick_rand(), 1'b1, 8'h55, 1'b0);
    drain();

    // second and third request during one frame
    step(tick_rand(), 1'b1, 8'h11, 1'b0);
    repeat (30) step(tick_rand(), 1'b0, '0, 1'b0);
    step(tick_rand(), 1'b1, 8'h22, 1'b0);
    repeat (30) step(tick_rand(), 1'b0, '0, 1'b0);
    step(tick_rand(), 1'b1, 8'h33, 1'b0);
    drain();

    // random traffic with random strobe spacing
    for (int k = 0; k < 15; k++) begin
      repeat ($urandom_range(50, 400))
        step(tick_rand(), ($urandom_range(0, 40) == 0), W'($urandom), 1'b0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
